rom_dl_ctrl: RTL and testbench

ROM download controller between the HPS ioctl stream and the SDRAM controller, palette/LUT BRAMs and core reset for the Tropical Angel core. It decodes each downloaded byte against the fixed ROM map and issues toggle-handshake writes on SDRAM port1 (CPU ROMs) and port2 (sprite ROMs, word-merged to 32-bit), or single-cycle BRAM write strobes. It also latches DIP bytes and owns the rom_loaded flag and the core reset stretcher.

---
 rtl/rom_dl_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_rom_dl_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_ctrl.sv
// ROM download controller for the Tropical Angel core.
// Decodes HPS ioctl bytes against the fixed ROM map. Each byte becomes one of:
//   - a toggle-handshake write on SDRAM port1 (CPU ROMs)
//   - a toggle-handshake write on SDRAM port2 (sprite ROMs)
//   - a one-cycle palette/LUT BRAM strobe
//   - a DIP byte latch
// It also owns rom_loaded, load_error and the core reset stretcher.
//
// Handshake: a request is raised by inverting portN_req while a/ds/d are held
// stable. The controller has accepted the write once portN_ack equals portN_req
// again. Ack is first compared on the cycle after the toggle, and at most one
// request is outstanding across both ports.
module rom_dl_ctrl #(
  parameter logic [15:0] RST_HOLD = 16'hFFFF,
  parameter logic [16:0] ROM_SIZE = 17'h1C320
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        user_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic [3:0]  bram_wr,
  output logic [7:0]  bram_addr,
  output logic [7:0]  bram_d,
  output logic [63:0] dip_sw,
  output logic        rom_loaded,
  output logic        load_error,
  output logic        core_reset
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;
  typedef enum logic [1:0] {T_P1, T_P2, T_BRAM, T_DROP} tgt_t;

  logic        wr_prev_q, dl_prev_q;
  logic        wr_rise, cap_rom, cap_dip, dl_rise, dl_fall;
  logic        hold_valid_q, hold_valid_d, skid_valid_q, skid_valid_d;
  logic [24:0] hold_addr_q, hold_addr_d, skid_addr_q, skid_addr_d;
  logic [7:0]  hold_data_q, hold_data_d, skid_data_q, skid_data_d;
  logic        overflow;
  state_t      state_q, state_d;
  tgt_t        tgt_q, tgt_d, src_tgt;
  logic [24:0] src_addr;
  logic [7:0]  src_data;
  logic [23:0] sp;
  logic        pop, issue, ack_match;
  logic        p1_req_q, p1_req_d, p2_req_q, p2_req_d;
  logic [22:0] p1_a_q, p1_a_d, p2_a_q, p2_a_d;
  logic [1:0]  p1_ds_q, p1_ds_d, p2_ds_q, p2_ds_d;
  logic [15:0] p1_d_q, p1_d_d, p2_d_q, p2_d_d;
  logic [3:0]  bram_wr_q, bram_wr_d;
  logic [7:0]  bram_addr_q, bram_addr_d, bram_d_q, bram_d_d;
  logic [63:0] dip_q, dip_d;
  logic [16:0] byte_cnt_q, byte_cnt_d;
  logic        end_pend_q, end_pend_d;
  logic        rom_loaded_q, rom_loaded_d, load_error_q, load_error_d;
  logic [15:0] rst_cnt_q, rst_cnt_d;
  logic        core_reset_q, core_reset_d;

  // Edge detection on the byte strobe and the download flag.
  always_comb begin
    wr_rise = ioctl_wr & ~wr_prev_q & ioctl_download;
    cap_rom = wr_rise & (ioctl_index == 8'd0);
    cap_dip = wr_rise & (ioctl_index == 8'd254) & (ioctl_addr[24:3] == 22'd0);
    dl_rise = ioctl_download & ~dl_prev_q & (ioctl_index == 8'd0);
    dl_fall = ~ioctl_download & dl_prev_q & (ioctl_index == 8'd0);
  end

  // Decode the byte about to be issued: the skid byte when chaining out of WAIT, otherwise hold.
  always_comb begin
    src_addr = (state_q == S_WAIT) ? skid_addr_q : hold_addr_q;
    src_data = (state_q == S_WAIT) ? skid_data_q : hold_data_q;
    sp       = src_addr[23:0] - 24'h010000;
    if (src_addr < 25'h0010000)      src_tgt = T_P1;
    else if (src_addr < 25'h001C000) src_tgt = T_P2;
    else if (src_addr < 25'h001C320) src_tgt = T_BRAM;
    else                             src_tgt = T_DROP;
    ack_match = (tgt_q == T_P2) ? (p2_req_q == port2_ack) : (p1_req_q == port1_ack);
  end

  // Shared port FSM; all port/BRAM outputs are registered from here.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    pop         = 1'b0;
    issue       = 1'b0;
    p1_req_d    = p1_req_q;
    p1_a_d      = p1_a_q;
    p1_ds_d     = p1_ds_q;
    p1_d_d      = p1_d_q;
    p2_req_d    = p2_req_q;
    p2_a_d      = p2_a_q;
    p2_ds_d     = p2_ds_q;
    p2_d_d      = p2_d_q;
    bram_wr_d   = 4'b0000;
    bram_addr_d = bram_addr_q;
    bram_d_d    = bram_d_q;
    case (state_q)
      S_IDLE:  if (hold_valid_q) issue = 1'b1;
      S_ISSUE: begin
        if (tgt_q == T_P1 || tgt_q == T_P2) begin
          state_d = S_WAIT;
        end else begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (ack_match) begin
          pop = 1'b1;
          if (skid_valid_q) issue = 1'b1;
          else              state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      state_d = S_ISSUE;
      tgt_d   = src_tgt;
      case (src_tgt)
        T_P1: begin
          p1_req_d = ~p1_req_q;
          p1_a_d   = src_addr[23:1];
          p1_ds_d  = {src_addr[0], ~src_addr[0]};
          p1_d_d   = {src_data, src_data};
        end
        T_P2: begin
          // Sprite ROM bytes are merged into 32-bit words across two 16-bit lanes.
          p2_req_d = ~p2_req_q;
          p2_a_d   = {sp[23:16], sp[13:0], sp[15]};
          p2_ds_d  = {sp[14], ~sp[14]};
          p2_d_d   = {src_data, src_data};
        end
        T_BRAM: begin
          bram_wr_d   = 4'b0001 << src_addr[9:8];
          bram_addr_d = src_addr[7:0];
          bram_d_d    = src_data;
        end
        default: ;
      endcase
    end
  end

  // Hold/skid queue. The hold byte stays valid until its write completes.
  // The skid byte refills hold on completion. A byte arriving with both full is lost.
  always_comb begin
    hold_valid_d = hold_valid_q & ~pop;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;
    overflow     = 1'b0;
    if (pop && skid_valid_q) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = skid_addr_q;
      hold_data_d  = skid_data_q;
      skid_valid_d = 1'b0;
    end
    if (cap_rom) begin
      if (!hold_valid_d) begin
        hold_valid_d = 1'b1;
        hold_addr_d  = ioctl_addr;
        hold_data_d  = ioctl_dout;
      end else if (!skid_valid_d) begin
        skid_valid_d = 1'b1;
        skid_addr_d  = ioctl_addr;
        skid_data_d  = ioctl_dout;
      end else begin
        overflow = 1'b1;
      end
    end
  end

  // DIP latch, byte counter and the loaded/error flags.
  always_comb begin
    dip_d        = dip_q;
    byte_cnt_d   = byte_cnt_q;
    end_pend_d   = end_pend_q;
    rom_loaded_d = rom_loaded_q;
    load_error_d = load_error_q | overflow;
    if (cap_dip) dip_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
    if (cap_rom && byte_cnt_q != 17'h1FFFF) byte_cnt_d = byte_cnt_q + 17'd1;
    if (dl_fall) end_pend_d = 1'b1;
    if (end_pend_q && state_q == S_IDLE && !hold_valid_q && !skid_valid_q) begin
      end_pend_d = 1'b0;
      if (byte_cnt_q >= ROM_SIZE) rom_loaded_d = 1'b1;
      else                        load_error_d = 1'b1;
    end
    if (dl_rise) begin
      byte_cnt_d   = 17'd0;
      end_pend_d   = 1'b0;
      rom_loaded_d = 1'b0;
      load_error_d = 1'b0;
    end
  end

  // Core reset stretcher: reload while any cause holds, then count down.
  always_comb begin
    if (user_reset | ~rom_loaded_q | (ioctl_download & (ioctl_index == 8'd0)))
      rst_cnt_d = RST_HOLD;
    else if (rst_cnt_q != 16'd0)
      rst_cnt_d = rst_cnt_q - 16'd1;
    else
      rst_cnt_d = 16'd0;
    core_reset_d = (rst_cnt_q != 16'd0);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_prev_q    <= 1'b0;
      dl_prev_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
      state_q      <= S_IDLE;
      tgt_q        <= T_DROP;
      p1_req_q     <= 1'b0;
      p1_a_q       <= '0;
      p1_ds_q      <= '0;
      p1_d_q       <= '0;
      p2_req_q     <= 1'b0;
      p2_a_q       <= '0;
      p2_ds_q      <= '0;
      p2_d_q       <= '0;
      bram_wr_q    <= '0;
      bram_addr_q  <= '0;
      bram_d_q     <= '0;
      dip_q        <= '0;
      byte_cnt_q   <= '0;
      end_pend_q   <= 1'b0;
      rom_loaded_q <= 1'b0;
      load_error_q <= 1'b0;
      rst_cnt_q    <= RST_HOLD;
      core_reset_q <= 1'b1;
    end else begin
      wr_prev_q    <= ioctl_wr;
      dl_prev_q    <= ioctl_download;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      p1_req_q     <= p1_req_d;
      p1_a_q       <= p1_a_d;
      p1_ds_q      <= p1_ds_d;
      p1_d_q       <= p1_d_d;
      p2_req_q     <= p2_req_d;
      p2_a_q       <= p2_a_d;
      p2_ds_q      <= p2_ds_d;
      p2_d_q       <= p2_d_d;
      bram_wr_q    <= bram_wr_d;
      bram_addr_q  <= bram_addr_d;
      bram_d_q     <= bram_d_d;
      dip_q        <= dip_d;
      byte_cnt_q   <= byte_cnt_d;
      end_pend_q   <= end_pend_d;
      rom_loaded_q <= rom_loaded_d;
      load_error_q <= load_error_d;
      rst_cnt_q    <= rst_cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign ioctl_wait = skid_valid_q;
  assign port1_req  = p1_req_q;
  assign port1_a    = p1_a_q;
  assign port1_ds   = p1_ds_q;
  assign port1_d    = p1_d_q;
  assign port2_req  = p2_req_q;
  assign port2_a    = p2_a_q;
  assign port2_ds   = p2_ds_q;
  assign port2_d    = p2_d_q;
  assign bram_wr    = bram_wr_q;
  assign bram_addr  = bram_addr_q;
  assign bram_d     = bram_d_q;
  assign dip_sw     = dip_q;
  assign rom_loaded = rom_loaded_q;
  assign load_error = load_error_q;
  assign core_reset = core_reset_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Directed bench for rom_dl_ctrl: decode map, handshake timing, skid/overflow,
// DIP latch, load verdict and reset stretcher length.
`timescale 1ns/1ps
module tb_rom_dl_ctrl;

  localparam logic [15:0] HOLD = 16'd40;
  localparam logic [16:0] RSZ  = 17'h00040;
  localparam logic [1:0]  ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2;

  logic        clk = 1'b0;
  logic        reset, user_reset, ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        ioctl_wait;
  logic        port1_req, port1_ack, port2_req, port2_ack;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;
  logic [3:0]  bram_wr;
  logic [7:0]  bram_addr, bram_d;
  logic [63:0] dip_sw;
  logic        rom_loaded, load_error, core_reset;
  logic [1:0]  st;

  int          checks = 0;
  int          failures = 0;
  logic        auto_ack = 1'b0;
  logic [15:0] exp_q[$];
  int          n;
  int          fall_at;

  rom_dl_ctrl #(.RST_HOLD(HOLD), .ROM_SIZE(RSZ)) dut (
    .clk(clk), .reset(reset), .user_reset(user_reset),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .bram_wr(bram_wr), .bram_addr(bram_addr), .bram_d(bram_d),
    .dip_sw(dip_sw), .rom_loaded(rom_loaded), .load_error(load_error),
    .core_reset(core_reset)
  );

  assign st = dut.state_q;

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; optionally echo both acks like an idle SDRAM controller.
  task automatic tick();
    @(negedge clk);
    if (auto_ack) begin
      port1_ack = port1_req;
      port2_ack = port2_req;
    end
  endtask

  task automatic pulse_wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int k = 0;
    while (ioctl_wait === 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("wait_bound", 64'(ioctl_wait), 64'd0);
    pulse_wr(a, d);
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic dl_stop();
    ioctl_download = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; user_reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0; port1_ack = 1'b0; port2_ack = 1'b0;
    tick(); tick();
    chk("rst_p1_req", 64'(port1_req), 64'd0);
    chk("rst_p2_req", 64'(port2_req), 64'd0);
    chk("rst_wait", 64'(ioctl_wait), 64'd0);
    chk("rst_bram_wr", 64'(bram_wr), 64'd0);
    chk("rst_dip", dip_sw, 64'd0);
    chk("rst_loaded", 64'(rom_loaded), 64'd0);
    chk("rst_error", 64'(load_error), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_state", 64'(st), 64'(ST_IDLE));
    reset = 1'b0;
    tick();

    // DIP bytes
    dl_start(8'd254);
    send_byte(25'h1, 8'h7F);
    chk("dip_byte1", dip_sw, 64'h0000_0000_0000_7F00);
    send_byte(25'h8, 8'h55);
    chk("dip_addr8_ignored", dip_sw, 64'h0000_0000_0000_7F00);
    send_byte(25'h7, 8'hC3);
    chk("dip_byte7", dip_sw, 64'hC300_0000_0000_7F00);
    chk("dip_no_req", 64'(port1_req), 64'd0);
    dl_stop();

    // port1 byte with latency and delayed ack
    dl_start(8'd0);
    ioctl_addr = 25'h3; ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
    tick();
    chk("p1_req_not_yet", 64'(port1_req), 64'd0);
    chk("p1_state_idle_cap", 64'(st), 64'(ST_IDLE));
    ioctl_wr = 1'b0;
    tick();
    chk("p1_req_toggle", 64'(port1_req), 64'd1);
    chk("p1_a", 64'(port1_a), 64'h000001);
    chk("p1_ds", 64'(port1_ds), 64'h2);
    chk("p1_d", 64'(port1_d), 64'hA5A5);
    chk("p1_state_issue", 64'(st), 64'(ST_ISSUE));
    tick();
    chk("p1_state_wait", 64'(st), 64'(ST_WAIT));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("p1_req_held", 64'(port1_req), 64'd1);
    end
    port1_ack = 1'b1;
    tick();
    chk("p1_idle_after_ack", 64'(st), 64'(ST_IDLE));
    chk("p1_single_toggle", 64'(port1_req), 64'd1);

    // port2 bytes
    send_byte(25'h14001, 8'h5A);
    chk("p2_req", 64'(port2_req), 64'd1);
    chk("p2_a_14001", 64'(port2_a), 64'h000002);
    chk("p2_d_14001", 64'(port2_d), 64'h5A5A);
    chk("p2_p1_unchanged", 64'(port1_req), 64'd1);
    port2_ack = 1'b1;
    tick(); tick();
    chk("p2_idle", 64'(st), 64'(ST_IDLE));
    send_byte(25'h18003, 8'h96);
    chk("p2_req2", 64'(port2_req), 64'd0);
    chk("p2_a_18003", 64'(port2_a), 64'h000007);
    chk("p2_ds_18003", 64'(port2_ds), 64'h1);
    chk("p2_d_18003", 64'(port2_d), 64'h9696);
    port2_ack = 1'b0;
    tick(); tick();

    // BRAM strobes and dropped address
    send_byte(25'h1C205, 8'h3C);
    chk("bram_wr_spr_pal", 64'(bram_wr), 64'h4);
    chk("bram_addr", 64'(bram_addr), 64'h05);
    chk("bram_d", 64'(bram_d), 64'h3C);
    chk("bram_no_p1", 64'(port1_req), 64'd1);
    chk("bram_no_p2", 64'(port2_req), 64'd0);
    tick();
    chk("bram_wr_one_cycle", 64'(bram_wr), 64'h0);
    chk("bram_state_idle", 64'(st), 64'(ST_IDLE));
    send_byte(25'h1C31F, 8'hE7);
    chk("bram_wr_lut", 64'(bram_wr), 64'h8);
    chk("bram_addr_top", 64'(bram_addr), 64'h1F);
    tick();
    send_byte(25'h1C320, 8'h5B);
    chk("drop_no_bram", 64'(bram_wr), 64'h0);
    tick();
    chk("drop_no_bram2", 64'(bram_wr), 64'h0);
    chk("drop_no_p1", 64'(port1_req), 64'd1);
    chk("drop_no_p2", 64'(port2_req), 64'd0);
    chk("drop_idle", 64'(st), 64'(ST_IDLE));

    // skid and overflow with ack withheld
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    pulse_wr(25'h10, 8'h11);
    chk("ovf_a_req", 64'(port1_req), 64'd0);
    chk("ovf_a_addr", 64'(port1_a), 64'h8);
    chk("ovf_a_ds", 64'(port1_ds), 64'h1);
    chk("ovf_a_d", 64'(port1_d), 64'(exp_q.pop_front()));
    chk("ovf_wait0", 64'(ioctl_wait), 64'd0);
    pulse_wr(25'h11, 8'h22);
    chk("ovf_wait1", 64'(ioctl_wait), 64'd1);
    chk("ovf_no_err_yet", 64'(load_error), 64'd0);
    pulse_wr(25'h12, 8'h33);
    chk("ovf_err", 64'(load_error), 64'd1);
    chk("ovf_wait_still", 64'(ioctl_wait), 64'd1);
    chk("ovf_a_still", 64'(port1_d), 64'h1111);
    port1_ack = 1'b0;
    tick();
    chk("drain_b_req", 64'(port1_req), 64'd1);
    chk("drain_b_addr", 64'(port1_a), 64'h8);
    chk("drain_b_ds", 64'(port1_ds), 64'h2);
    chk("drain_b_d", 64'(port1_d), 64'(exp_q.pop_front()));
    chk("drain_wait0", 64'(ioctl_wait), 64'd0);
    port1_ack = 1'b1;
    tick(); tick(); tick();
    chk("drain_idle", 64'(st), 64'(ST_IDLE));
    chk("drain_c_dropped", 64'(port1_req), 64'd1);
    dl_stop();
    tick(); tick(); tick();
    chk("short_session_err", 64'(load_error), 64'd1);
    chk("short_session_not_loaded", 64'(rom_loaded), 64'd0);

    // exact ROM_SIZE download
    auto_ack = 1'b1;
    dl_start(8'd0);
    chk("full_err_cleared", 64'(load_error), 64'd0);
    for (int i = 0; i < 64; i++) send_byte(25'(i), 8'(i));
    dl_stop();
    n = 0;
    while (rom_loaded !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("full_loaded", 64'(rom_loaded), 64'd1);
    chk("full_no_err", 64'(load_error), 64'd0);
    fall_at = -1;
    for (int j = 1; j <= int'(HOLD) + 10; j++) begin
      tick();
      if (core_reset === 1'b0) begin
        fall_at = j;
        break;
      end
    end
    chk("core_reset_fall", 64'(fall_at), 64'(int'(HOLD) + 1));

    // one byte short of ROM_SIZE
    dl_start(8'd0);
    chk("short_loaded_cleared", 64'(rom_loaded), 64'd0);
    for (int i = 0; i < 63; i++) send_byte(25'(i), 8'(i));
    dl_stop();
    n = 0;
    while (load_error !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("short_err", 64'(load_error), 64'd1);
    chk("short_not_loaded", 64'(rom_loaded), 64'd0);
    for (int i = 0; i < 60; i++) tick();
    chk("short_core_reset_held", 64'(core_reset), 64'd1);

    // async reset mid-handshake
    auto_ack = 1'b0;
    dl_start(8'd0);
    pulse_wr(25'h30, 8'h44);
    chk("pre_rst_req", 64'(port1_req), 64'd1);
    #2;
    reset = 1'b1; port1_ack = 1'b0; port2_ack = 1'b0;
    #1;
    chk("arst_p1_req", 64'(port1_req), 64'd0);
    chk("arst_state", 64'(st), 64'(ST_IDLE));
    chk("arst_core_reset", 64'(core_reset), 64'd1);
    tick();
    reset = 1'b0;
    ioctl_download = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
